seg_lfsr_checker: RTL and testbench
===================================

// Module: seg_lfsr_checker
// PURPOSE
//  Receive side of the 8-bit LFSR seven-segment display link.
//  - Takes two active-low segment codes per step (high nibble, low nibble).
//  - Decodes them back to a byte and locks onto the LFSR sequence.
//  - Predicts each following value; flags and counts mismatches and illegal glyphs.
//  - Sits between the display-pattern source and the board status LEDs / debug counters.
// PARAMETERS
//  ERR_LIMIT  3   consecutive mismatches while LOCKED that force resync (>=1)
//  CNT_W      16  width of saturating error counter
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      asynchronous, active-low reset
//  in_valid   in   1      one LFSR step presented this cycle
//  seg_hi     in   8      active-low segment code, high nibble; bit0 = dp
//  seg_lo     in   8      active-low segment code, low nibble; bit0 = dp
//  value      out  8      last decoded byte
//  value_vld  out  1      1-cycle pulse: value updated
//  locked     out  1      sequence tracking active
//  mismatch   out  1      1-cycle pulse: locked sample != prediction
//  seg_err    out  1      1-cycle pulse: illegal glyph on either input
//  err_cnt    out  CNT_W  saturating count of mismatch + seg_err events
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, FSM=IDLE, predictor regs 0.
//  Decode table, active-low code -> nibble:
//   02->0 9F->1 25->2 0D->3 99->4 49->5 41->6 1F->7
//   01->8 09->9 05->A C1->B 63->C 85->D 61->E 71->F
//  Decode rules:
//   - Any other code is illegal: seg_err=1 next cycle; sample discarded.
//   - An illegal sample does not change value or the FSM, except that in ACQ1 it returns the FSM to IDLE.
//  Latency: all outputs registered; sample at edge N -> value/value_vld/flags valid after edge N.
//  Reference sequence (q, t):
//   - q==0 -> q'=8'h01, t'=t.
//   - Otherwise q'={t,q[7:1]}, t'=q[4]^q[3]^q[2]^q[0].
//  FSM:
//   - IDLE: legal sample d -> store p=d, go to ACQ1.
//   - ACQ1: legal sample d is consistent if (p!=0 && d[6:0]==p[7:1]) or (p==0 && d==8'h01).
//     - Consistent: t:=f(p) if p!=0, else t:=d[7]; pred:=next(d,t); locked=1; go to LOCKED.
//     - Inconsistent: p:=d; stay in ACQ1.
//   - LOCKED: legal sample d:
//     - d==pred: clear the miss counter; advance pred.
//     - d!=pred: mismatch pulse; miss+1; pred advances from the received d; t is kept.
//     - miss reaching ERR_LIMIT: locked=0, go to IDLE, miss:=0.
//  err_cnt:
//   - +1 per cycle in which mismatch or seg_err is asserted (+1 even if both).
//   - Saturates at all-ones.
//  in_valid=0: no state change; all pulses 0.
//  Reset mid-stream: immediate return to IDLE; no partial lock is retained.
// CONFIGURATION
//  SEG_DP_MASK_EN:
//   - Defined: bit0 (dp) of seg_hi/seg_lo is ignored in decode; table matched on bits[7:1] only.
//   - Undefined: all 8 bits must match exactly; a wrong dp is seg_err.
// TESTING
//  1 Reset, then legal sequence 8'h5A,8'h2D,...: locked=1 after the 2nd sample; no mismatch over 300 steps.
//  2 Locked, inject 8'h00 in place of the expected value: mismatch pulse, err_cnt=1; the next correct sample resumes the count from 0.
//  3 ERR_LIMIT=3, three wrong samples: locked drops on the 3rd; two correct samples relock.
//  4 seg_lo=8'hFF (blank): seg_err=1, err_cnt+1, value unchanged.
//  5 Sample q=8'h00 then 8'h01: lock succeeds via the zero-escape rule.
//  6 Drive err_cnt to all-ones (CNT_W=4): it holds at 15; assert rst mid-stream: all outputs 0 asynchronously.
//  7 (SEG_DP_MASK_EN) 0 sent as 8'h03: decodes as 0; without the macro: seg_err.

Source files
------------

// File: rtl/seg_lfsr_checker.sv
// seg_lfsr_checker: receive side of the 8-bit LFSR seven-segment display link.
// Two active-low glyphs per step are decoded back to a byte. The checker locks
// onto the LFSR sequence, predicts each following value, and pulses/counts
// mismatches and illegal glyphs.
// Build option: define SEG_DP_MASK_EN to ignore the dp bit (bit0) of both
// glyphs during decode; when undefined, all 8 bits must match exactly.
module seg_lfsr_checker #(
  parameter int ERR_LIMIT = 3,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       seg_hi,
  input  logic [7:0]       seg_lo,
  output logic [7:0]       value,
  output logic             value_vld,
  output logic             locked,
  output logic             mismatch,
  output logic             seg_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int MISS_W = $clog2(ERR_LIMIT + 1);

`ifdef SEG_DP_MASK_EN
  // With dp ignored, every key has bit0 forced high, so the '0' glyph 02 becomes 03.
  localparam logic [7:0] ZERO_KEY = 8'h03;
`else
  localparam logic [7:0] ZERO_KEY = 8'h02;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ1   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Glyph -> {legal, nibble}; illegal codes return legal=0.
  function automatic logic [4:0] seg_decode(input logic [7:0] code);
    logic [7:0] key;
    logic [4:0] res;
`ifdef SEG_DP_MASK_EN
    key = {code[7:1], 1'b1};
`else
    key = code;
`endif
    case (key)
      ZERO_KEY: res = 5'h10;
      8'h9F:    res = 5'h11;
      8'h25:    res = 5'h12;
      8'h0D:    res = 5'h13;
      8'h99:    res = 5'h14;
      8'h49:    res = 5'h15;
      8'h41:    res = 5'h16;
      8'h1F:    res = 5'h17;
      8'h01:    res = 5'h18;
      8'h09:    res = 5'h19;
      8'h05:    res = 5'h1A;
      8'hC1:    res = 5'h1B;
      8'h63:    res = 5'h1C;
      8'h85:    res = 5'h1D;
      8'h61:    res = 5'h1E;
      8'h71:    res = 5'h1F;
      default:  res = 5'h00;
    endcase
    return res;
  endfunction

  // LFSR feedback taps (bits 4,3,2,0).
  function automatic logic lfsr_fb(input logic [7:0] q);
    return q[4] ^ q[3] ^ q[2] ^ q[0];
  endfunction

  // Next value of the sequence; zero escapes to 8'h01.
  function automatic logic [7:0] lfsr_shift(input logic [7:0] q, input logic t);
    logic [7:0] res;
    if (q == 8'h00) begin
      res = 8'h01;
    end else begin
      res = {t, q[7:1]};
    end
    return res;
  endfunction

  // Next pending top bit; the zero escape leaves it untouched.
  function automatic logic lfsr_tnext(input logic [7:0] q, input logic t);
    logic res;
    if (q == 8'h00) begin
      res = t;
    end else begin
      res = lfsr_fb(q);
    end
    return res;
  endfunction

  state_t             state_r;
  logic [7:0]         p_r;
  logic [7:0]         pred_r;
  logic               t_r;
  logic [MISS_W-1:0]  miss_r;
  logic [7:0]         value_r;
  logic               value_vld_r;
  logic               locked_r;
  logic               mismatch_r;
  logic               seg_err_r;
  logic [CNT_W-1:0]   err_cnt_r;

  logic [4:0]         hi_dec_s;
  logic [4:0]         lo_dec_s;
  logic               legal_s;
  logic [7:0]         d_s;
  logic               consistent_s;
  logic               t_acq_s;
  logic               err_evt_s;
  logic [MISS_W-1:0]  miss_inc_s;

  // Decode the glyph pair and derive acquisition / error-event conditions.
  always_comb begin
    hi_dec_s   = seg_decode(seg_hi);
    lo_dec_s   = seg_decode(seg_lo);
    legal_s    = hi_dec_s[4] & lo_dec_s[4];
    d_s        = {hi_dec_s[3:0], lo_dec_s[3:0]};
    miss_inc_s = miss_r + MISS_W'(1);
    if (p_r != 8'h00) begin
      consistent_s = (d_s[6:0] == p_r[7:1]);
      t_acq_s      = lfsr_fb(p_r);
    end else begin
      consistent_s = (d_s == 8'h01);
      t_acq_s      = d_s[7];
    end
    if (!in_valid) begin
      err_evt_s = 1'b0;
    end else if (!legal_s) begin
      err_evt_s = 1'b1;
    end else if ((state_r == ST_LOCKED) && (d_s != pred_r)) begin
      err_evt_s = 1'b1;
    end else begin
      err_evt_s = 1'b0;
    end
  end

  // Acquisition/tracking FSM, predictor, registered outputs and error counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      p_r         <= 8'h00;
      pred_r      <= 8'h00;
      t_r         <= 1'b0;
      miss_r      <= '0;
      value_r     <= 8'h00;
      value_vld_r <= 1'b0;
      locked_r    <= 1'b0;
      mismatch_r  <= 1'b0;
      seg_err_r   <= 1'b0;
      err_cnt_r   <= '0;
    end else begin
      value_vld_r <= 1'b0;
      mismatch_r  <= 1'b0;
      seg_err_r   <= 1'b0;
      if (err_evt_s && (err_cnt_r != {CNT_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + CNT_W'(1);
      end
      if (in_valid) begin
        if (!legal_s) begin
          // Illegal glyph: sample dropped; a half-built lock is abandoned.
          seg_err_r <= 1'b1;
          if (state_r == ST_ACQ1) begin
            state_r <= ST_IDLE;
          end
        end else begin
          value_r     <= d_s;
          value_vld_r <= 1'b1;
          case (state_r)
            ST_IDLE: begin
              p_r     <= d_s;
              state_r <= ST_ACQ1;
            end
            ST_ACQ1: begin
              if (consistent_s) begin
                pred_r   <= lfsr_shift(d_s, t_acq_s);
                t_r      <= lfsr_tnext(d_s, t_acq_s);
                miss_r   <= '0;
                locked_r <= 1'b1;
                state_r  <= ST_LOCKED;
              end else begin
                p_r <= d_s;
              end
            end
            ST_LOCKED: begin
              if (d_s == pred_r) begin
                miss_r <= '0;
                pred_r <= lfsr_shift(pred_r, t_r);
                t_r    <= lfsr_tnext(pred_r, t_r);
              end else begin
                // Re-predict from what was received; the pending top bit is kept.
                mismatch_r <= 1'b1;
                pred_r     <= lfsr_shift(d_s, t_r);
                if (miss_inc_s == MISS_W'(ERR_LIMIT)) begin
                  miss_r   <= '0;
                  locked_r <= 1'b0;
                  state_r  <= ST_IDLE;
                end else begin
                  miss_r <= miss_inc_s;
                end
              end
            end
            default: begin
              locked_r <= 1'b0;
              miss_r   <= '0;
              state_r  <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign value     = value_r;
  assign value_vld = value_vld_r;
  assign locked    = locked_r;
  assign mismatch  = mismatch_r;
  assign seg_err   = seg_err_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_seg_lfsr_checker.sv
// Bench for seg_lfsr_checker: directed vectors, a behavioural model checked
// every cycle, and hand-computed literal expectations.
module tb_seg_lfsr_checker;

  localparam int ERR_LIMIT = 3;
  localparam int CNT_W     = 4;
`ifdef SEG_DP_MASK_EN
  localparam bit DP_MASK = 1'b1;
`else
  localparam bit DP_MASK = 1'b0;
`endif

  logic             clk      = 1'b0;
  logic             rst      = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       seg_hi   = 8'hFF;
  logic [7:0]       seg_lo   = 8'hFF;
  logic [7:0]       value;
  logic             value_vld;
  logic             locked;
  logic             mismatch;
  logic             seg_err;
  logic [CNT_W-1:0] err_cnt;

  seg_lfsr_checker #(.ERR_LIMIT(ERR_LIMIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .seg_hi(seg_hi), .seg_lo(seg_lo),
    .value(value), .value_vld(value_vld), .locked(locked), .mismatch(mismatch),
    .seg_err(seg_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] seg_tab [16] = '{8'h02, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h05, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  // model state: mode 0 = waiting for first sample, 1 = one sample held, 2 = tracking
  int         m_mode;
  logic [7:0] m_p, m_pred, m_value;
  logic       m_t, m_vld, m_locked, m_mis, m_serr;
  int         m_miss, m_cnt;

  function automatic bit tb_decode(input logic [7:0] code, output logic [3:0] nib);
    nib = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (DP_MASK ? (code[7:1] == seg_tab[i][7:1]) : (code == seg_tab[i])) begin
        nib = 4'(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_p = 8'h00; m_pred = 8'h00; m_t = 1'b0; m_miss = 0; m_cnt = 0;
    m_value = 8'h00; m_vld = 1'b0; m_locked = 1'b0; m_mis = 1'b0; m_serr = 1'b0;
  endtask

  task automatic model_bump();
    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
  endtask

  // one reference LFSR step on (q,t)
  task automatic ref_adv(inout logic [7:0] q, inout logic t);
    logic nt;
    if (q == 8'h00) begin
      q = 8'h01;
    end else begin
      nt = ^(q & 8'h1D);
      q  = {t, q[7:1]};
      t  = nt;
    end
  endtask

  task automatic model_step(input logic v, input logic [7:0] hi, input logic [7:0] lo);
    logic [3:0] nh, nl;
    logic [7:0] d, q;
    logic       tt;
    bit         okh, okl;
    m_vld = 1'b0; m_mis = 1'b0; m_serr = 1'b0;
    if (v) begin
      okh = tb_decode(hi, nh);
      okl = tb_decode(lo, nl);
      if (!(okh && okl)) begin
        m_serr = 1'b1;
        model_bump();
        if (m_mode == 1) m_mode = 0;
      end else begin
        d = {nh, nl};
        m_value = d;
        m_vld = 1'b1;
        if (m_mode == 0) begin
          m_p = d;
          m_mode = 1;
        end else if (m_mode == 1) begin
          if ((m_p != 8'h00 && d[6:0] == m_p[7:1]) || (m_p == 8'h00 && d == 8'h01)) begin
            tt = (m_p != 8'h00) ? ^(m_p & 8'h1D) : d[7];
            q = d;
            ref_adv(q, tt);
            m_pred = q; m_t = tt; m_locked = 1'b1; m_mode = 2; m_miss = 0;
          end else begin
            m_p = d;
          end
        end else begin
          if (d == m_pred) begin
            m_miss = 0;
            q = m_pred; tt = m_t;
            ref_adv(q, tt);
            m_pred = q; m_t = tt;
          end else begin
            m_mis = 1'b1;
            model_bump();
            m_pred = (d == 8'h00) ? 8'h01 : {m_t, d[7:1]};
            m_miss++;
            if (m_miss >= ERR_LIMIT) begin
              m_locked = 1'b0; m_mode = 0; m_miss = 0;
            end
          end
        end
      end
    end
  endtask

  // model follows the DUT edge by edge; outputs compared 1 ns after every edge
  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step(in_valid, seg_hi, seg_lo);
    #1;
    nvec++;
    if (value !== m_value || value_vld !== m_vld || locked !== m_locked ||
        mismatch !== m_mis || seg_err !== m_serr || int'(err_cnt) != m_cnt) begin
      nerr++;
      $display("FAIL cycle_cmp t=%0t got val=%h vld=%b lock=%b mis=%b serr=%b cnt=%0d want val=%h vld=%b lock=%b mis=%b serr=%b cnt=%0d",
               $time, value, value_vld, locked, mismatch, seg_err, err_cnt,
               m_value, m_vld, m_locked, m_mis, m_serr, m_cnt);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] hi, input logic [7:0] lo);
    @(negedge clk);
    in_valid = v; seg_hi = hi; seg_lo = lo;
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive(1'b1, seg_tab[b[7:4]], seg_tab[b[3:0]]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [7:0] g_q;
  logic       g_t;

  initial begin
    // reset state
    do_reset();
    #1;
    chk("reset_value", int'(value), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_cnt", int'(err_cnt), 0);

    // 1: lock on 5A,2D and track 300 steps
    g_q = 8'h5A; g_t = 1'b0;
    for (int k = 0; k < 300; k++) begin
      send_byte(g_q);
      if (k == 0) chk("not_locked_after_1", int'(locked), 0);
      if (k == 1) begin
        chk("locked_after_2", int'(locked), 1);
        chk("value_2D", int'(value), 8'h2D);
      end
      if (k == 2) chk("value_16", int'(value), 8'h16);
      if (k == 3) chk("value_8B", int'(value), 8'h8B);
      ref_adv(g_q, g_t);
    end
    chk("track_locked", int'(locked), 1);
    chk("track_no_err", int'(err_cnt), 0);

    // 2: inject 00 where 16 is expected, then the re-predicted 01
    do_reset();
    send_byte(8'h5A);
    send_byte(8'h2D);
    send_byte(8'h00);
    chk("inj_mismatch", int'(mismatch), 1);
    chk("inj_cnt", int'(err_cnt), 1);
    send_byte(8'h01);
    chk("resume_no_mis", int'(mismatch), 0);
    chk("resume_locked", int'(locked), 1);

    // 3: three wrong samples drop the lock on the third
    send_byte(8'h55);
    send_byte(8'h55);
    chk("two_wrong_locked", int'(locked), 1);
    send_byte(8'h55);
    chk("third_wrong_unlock", int'(locked), 0);
    chk("third_wrong_cnt", int'(err_cnt), 4);
    send_byte(8'h5A);
    send_byte(8'h2D);
    chk("relock", int'(locked), 1);

    // 4: blank low glyph
    drive(1'b1, seg_tab[3], 8'hFF);
    chk("blank_seg_err", int'(seg_err), 1);
    chk("blank_cnt", int'(err_cnt), 5);
    chk("blank_value_kept", int'(value), 8'h2D);
    drive(1'b0, 8'hFF, 8'hFF);
    chk("idle_no_pulse", int'(seg_err), 0);

    // 5: zero-escape lock
    do_reset();
    send_byte(8'h00);
    send_byte(8'h01);
    chk("zero_escape_lock", int'(locked), 1);

    // illegal sample while holding one sample restarts acquisition
    do_reset();
    send_byte(8'h5A);
    drive(1'b1, 8'hFF, 8'hFF);
    send_byte(8'h2D);
    chk("acq_abort_unlocked", int'(locked), 0);
    send_byte(8'h16);
    chk("acq_abort_relock", int'(locked), 1);

    // 6: saturate the 4-bit counter, then async reset mid-stream
    do_reset();
    repeat (20) drive(1'b1, seg_tab[1], 8'h00);
    chk("cnt_saturated", int'(err_cnt), 15);
    send_byte(8'h5A);
    send_byte(8'h2D);
    chk("sat_locked", int'(locked), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_locked", int'(locked), 0);
    chk("async_value", int'(value), 0);
    chk("async_cnt", int'(err_cnt), 0);
    chk("async_vld", int'(value_vld), 0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;

    // 7: '0' glyph with dp bit set
    do_reset();
    drive(1'b1, 8'h03, seg_tab[5]);
`ifdef SEG_DP_MASK_EN
    chk("dp_masked_value", int'(value), 8'h05);
    chk("dp_masked_no_err", int'(seg_err), 0);
`else
    chk("dp_exact_seg_err", int'(seg_err), 1);
    chk("dp_exact_value", int'(value), 0);
`endif
    drive(1'b0, 8'hFF, 8'hFF);
    drive(1'b0, 8'hFF, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
